// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root block: controller states and
// the default radicand width.
package sqrt_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings down the next
// radicand bit pair and resolves one root bit.
module sqrt_step #(
  parameter int HALF = 4
) (
  input  logic [HALF:0]   rem_i,
  input  logic [HALF-1:0] root_i,
  input  logic [1:0]      pair_i,
  output logic [HALF:0]   rem_o,
  output logic [HALF-1:0] root_o
);
  localparam int RW = HALF + 1;

  logic [HALF+2:0] trial;
  logic [HALF+2:0] divisor;
  logic [HALF+2:0] diff;

  always_comb begin
    trial   = {rem_i, pair_i};
    divisor = {1'b0, root_i, 2'b01};
    diff    = trial - divisor;
    // The remainder never exceeds 2*root, so it always fits back in HALF+1 bits.
    if (trial >= divisor) begin
      rem_o  = RW'(diff);
      root_o = (root_i << 1) | HALF'(1);
    end else begin
      rem_o  = RW'(trial);
      root_o = root_i << 1;
    end
  end
endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root: one root bit per clock, floor or rounded root,
// floor remainder, request/drop handshake with fully registered outputs.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ROUND = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x_in,
  input  logic               x_ready,
  output logic [WIDTH/2-1:0] y_out,
  output logic [WIDTH/2:0]   rem_out,
  output logic               y_ready,
  output logic               busy,
  output logic               x_drop
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(HALF + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [HALF:0]   rem_q, rem_d;
  logic [HALF-1:0] root_q, root_d;
  logic [HALF-1:0] y_q, y_d;
  logic [HALF:0]   remo_q, remo_d;
  logic            yr_q, yr_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;

  logic [HALF:0]   step_rem;
  logic [HALF-1:0] step_root;
  logic [HALF-1:0] y_fin;

  sqrt_step #(.HALF(HALF)) u_step (
    .rem_i  (rem_q),
    .root_i (root_q),
    .pair_i (x_q[WIDTH-1 -: 2]),
    .rem_o  (step_rem),
    .root_o (step_root)
  );

  // Rounding uses rem > r, equivalent to x >= (r + 0.5)^2; all-ones root saturates.
  always_comb begin
    y_fin = step_root;
    if (ROUND != 0 && step_rem > {1'b0, step_root} && step_root != '1)
      y_fin = step_root + HALF'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    y_d     = y_q;
    remo_d  = remo_q;
    yr_d    = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (x_ready) begin
          x_d     = x_in;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(HALF);
          state_d = CALC;
        end
      end
      CALC: begin
        drop_d = x_ready;
        rem_d  = step_rem;
        root_d = step_root;
        x_d    = x_q << 2;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          y_d     = y_fin;
          remo_d  = step_rem;
          yr_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        drop_d  = x_ready;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      y_q     <= '0;
      remo_q  <= '0;
      yr_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      y_q     <= y_d;
      remo_q  <= remo_d;
      yr_q    <= yr_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign y_out   = y_q;
  assign rem_out = remo_q;
  assign y_ready = yr_q;
  assign busy    = busy_q;
  assign x_drop  = drop_q;
endmodule

// File: doc/sqrt_iter.md
SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 8; radicand width; even, >= 4.
REQ-002 SHALL have parameter ROUND, default 0; 0 = floor root, 1 = round-to-nearest root.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 x_in  input  WIDTH  unsigned radicand, sampled only on acceptance.
REQ-007 x_ready  input  1  request strobe; high = x_in valid this cycle.
REQ-008 y_out  output  WIDTH/2  root result.
REQ-009 rem_out  output  WIDTH/2+1  floor remainder, x - floor_root^2.
REQ-010 y_ready  output  1  one-cycle pulse; y_out/rem_out newly valid.
REQ-011 busy  output  1  high whenever not IDLE.
REQ-012 x_drop  output  1  one-cycle pulse; a request was rejected.

Function
REQ-013 FSM SHALL have states IDLE, CALC, DONE.
REQ-014 IDLE with x_ready=1 at an edge: SHALL capture x_in, clear the partial root and remainder, load the iteration counter with WIDTH/2, and go to CALC.
REQ-015 CALC: SHALL resolve one root bit per edge, two radicand bits per edge, MSB pair first (restoring digit-by-digit).
REQ-016 CALC SHALL last exactly WIDTH/2 edges; on the last one SHALL load y_out, rem_out, assert y_ready, and go to DONE.
REQ-017 DONE SHALL return to IDLE on the next edge and deassert y_ready; y_ready SHALL never be high for two consecutive cycles.
REQ-018 Latency: acceptance at edge 0 -> y_ready high during the cycle after edge WIDTH/2; minimum spacing between acceptances WIDTH/2+2 edges.
REQ-019 y_out/rem_out SHALL hold their last result until the next y_ready.
REQ-020 ROUND=0: y_out = floor(sqrt(x)).
REQ-021 ROUND=1: y_out = r+1 if rem > r, else r (r = floor root); if r = 2^(WIDTH/2)-1, SHALL saturate at r.
REQ-022 rem_out SHALL be the floor remainder in both modes; max value 2^(WIDTH/2+1)-2 fits without truncation.
REQ-023 x_ready=1 in CALC or DONE: SHALL be ignored and SHALL pulse x_drop for one cycle; operation in flight is unaffected.
REQ-024 x_ready held high in IDLE: each acceptance SHALL be a new operation; back-to-back holding yields one result per WIDTH/2+2 cycles.
REQ-025 x_in changes during CALC SHALL not affect the result.

Reset
REQ-026 rst low SHALL asynchronously force state IDLE, y_out=0, rem_out=0, y_ready=0, busy=0, x_drop=0, internal registers 0.
REQ-027 Reset mid-CALC SHALL abort without emitting y_ready; first acceptance is possible on the first edge with rst high.

Structure
REQ-028 Package sqrt_pkg SHALL hold the state typedef (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-029 One sub-module, sqrt_step, SHALL be the combinational single-digit iteration: takes remainder, root, next radicand pair; returns updated remainder and root.
REQ-030 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-031 WIDTH=8, ROUND=0, x=203 held 1 cycle -> y_ready pulse 4 edges later, y_out=14, rem_out=7.
REQ-032 WIDTH=8, ROUND=1: x=211 -> y_out=15, rem_out=15; x=210 -> y_out=14, rem_out=14; x=255 -> y_out=15 (saturated), rem_out=30.
REQ-033 WIDTH=8: x=0 -> y_out=0, rem_out=0; x=240 -> y_out=15, rem_out=15 both modes.
REQ-034 WIDTH=16, ROUND=0, x=65535 -> y_out=255, rem_out=510 after 8 CALC edges.
REQ-035 x_ready pulsed during CALC -> x_drop one-cycle pulse, original result unchanged; rst low mid-CALC -> no y_ready, all outputs 0, busy 0.
REQ-036 Exhaustive WIDTH=8 sweep, both modes, x_ready held high -> every result matches reference model; y_ready spacing exactly 6 cycles.
